spi_slave_sync: RTL
===================

// Module: spi_slave_sync
// PURPOSE
//  SPI slave that oversamples SCK/MOSI/CS in the system clock domain. Replaces the SCK-clocked slave.
//  Configurable word width and SPI mode (CPOL/CPHA). Adds a valid/ready TX holding register,
//  a single-cycle RX strobe, a first-word flag and underrun reporting.
//  Sits between the external MCU SPI pins and the register/command decoder.
//  Requires clk >= 8x SCK.
// PARAMETERS
//  WIDTH      8     bits per SPI word (2..32)
//  CPOL       0     SCK idle level
//  CPHA       0     0: sample on leading edge, shift on trailing; 1: shift leading, sample trailing
//  CS_ACT     1     active level of cs (1 = positive CS, as on current board)
//  FILL       0     WIDTH-bit word shifted out when TX holding register is empty
// PORTS
//  clk         in   1      system clock; every register is on posedge clk
//  rst_n       in   1      synchronous active-low reset
//  sck         in   1      SPI clock, asynchronous to clk
//  mosi        in   1      SPI data in, asynchronous
//  cs          in   1      chip select, asynchronous, polarity CS_ACT
//  miso        out  1      SPI data out = MSB of TX shift register
//  miso_oe     out  1      1 while selected (synchronized cs active)
//  tx_data     in   WIDTH  next word to send
//  tx_valid    in   1      tx_data valid
//  tx_ready    out  1      holding register empty; transfer on tx_valid & tx_ready
//  rx_data     out  WIDTH  last complete received word, held until next word
//  rx_valid    out  1      one-clk strobe, rx_data updated this cycle
//  rx_first    out  1      qualifies rx_valid: first word since cs asserted
//  tx_underrun out  1      one-clk strobe: FILL loaded because holding register empty
//  busy        out  1      selected and bit_cnt != 0 (mid-word)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): all state 0.
//    tx_ready=1, rx_valid=rx_first=tx_underrun=busy=miso_oe=0, rx_data=0, miso=0.
//  - sck, mosi and cs each pass through a 2-FF synchronizer plus one history FF.
//    Edges are detected from the history/sync pair, so an edge is seen 3 clk after the pin.
//    mosi takes the same path as sck, so it is sampled with the same delay.
//  - Leading edge = sck leaves CPOL; trailing edge = sck returns to CPOL.
//    Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
//    Edges are ignored while deselected.
//  - Select (cs becomes CS_ACT):
//      - bit_cnt=0, first=1.
//      - tx_shift <= holding register if full (holding register empties), else FILL and pulse tx_underrun.
//      - skip=CPHA.
//  - Sample edge:
//      - rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt++.
//      - At bit_cnt==WIDTH-1: rx_data <= {rx_shift, mosi_s}; rx_valid=1 and rx_first=first for 1 clk;
//        first<=0; bit_cnt<=0; load<=1.
//  - Shift edge:
//      - skip=1: skip<=0, no shift (CPHA=1 first leading edge).
//      - else load=1: load<=0; tx_shift loaded as at select (holding register or FILL + underrun).
//      - else shift tx_shift left, LSB 0.
//  - Deselect (cs leaves CS_ACT), including mid-word:
//      - bit_cnt=0; partial RX word discarded, no rx_valid; load=0.
//      - The holding register is kept; the partially sent word is lost.
//  - Simultaneous holding-register load and tx_valid&tx_ready in the same clk: the load takes the old
//    contents and the new word is written. tx_ready is registered and drops the cycle after acceptance.
//  - Sync reset mid-transfer returns to reset state; the next word starts only after a fresh select edge.
//  - Widths: bit_cnt is $clog2(WIDTH) bits and wraps only through the WIDTH-1 compare.
//    No arithmetic on data.
// STRUCTURE
//  - spi_pkg: constants SPI_MODE0..3 (CPOL/CPHA pairs); function leading_edge(cpol, prev, cur).
//  - Sub-module sync2 (2-FF synchronizer, 1 bit), instanced for sck, mosi and cs.
//  - Top holds edge detect, bit counter, RX/TX shift registers and holding-register handshake.
// TESTING
//  1. Mode 0, WIDTH=8, holding register 0xA5 preloaded, master sends 0x3C.
//     -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid&rx_first one clk; tx_ready back to 1.
//  2. Two back-to-back words without deselect, 0x11 then 0x22, tx 0x80 then 0x01.
//     -> rx_valid twice, rx_first only on the first; second miso word = 0x01.
//  3. Holding register empty at select.
//     -> tx_underrun pulse, miso shifts FILL=0x00; next tx_valid accepted normally.
//  4. cs deasserted after 5 bits, then full word 0xF0.
//     -> no rx_valid for the partial word; rx_data=0xF0 with rx_first=1.
//  5. Modes 1, 2 and 3 with WIDTH=16, master sends 0xBEEF, tx 0x1234.
//     -> rx_data=0xBEEF, master receives 0x1234 in every mode.
//  6. rst_n low mid-word for 1 clk.
//     -> all outputs at reset values next cycle; no rx_valid until a new select.

Source files
------------

// File: rtl/spi_slave_sync_pkg.sv
// Shared SPI mode constants and edge helper for the oversampling SPI slave.
package spi_pkg;

  // Mode encoding is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic leading_edge(input logic cpol, input logic prev, input logic cur);
    return (prev == cpol) && (cur != cpol);
  endfunction

endpackage

// File: rtl/spi_slave_sync_sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampling sck/mosi/cs in the clk domain, with a valid/ready TX
// holding register, single-cycle RX strobe, first-word flag and underrun strobe.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic             CPOL   = 1'b0,
  parameter logic             CPHA   = 1'b0,
  parameter logic             CS_ACT = 1'b1,
  parameter logic [WIDTH-1:0] FILL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             mosi,
  input  logic             cs,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic sck_s, mosi_s, cs_s;

  sync2 u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
  sync2 u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));
  sync2 u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .q(cs_s));

  logic             sck_h_q, sck_h_d;
  logic             cs_h_q, cs_h_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             first_q, first_d;
  logic             skip_q, skip_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_first_q, rx_first_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_oe_q, miso_oe_d;
  logic             busy_q, busy_d;

  logic sel, sel_prev, lead, trail, sample_e, shift_e, load_tx;

  always_comb begin
    sel      = (cs_s == CS_ACT);
    sel_prev = (cs_h_q == CS_ACT);
    lead     = leading_edge(CPOL, sck_h_q, sck_s);
    trail    = leading_edge(~CPOL, sck_h_q, sck_s);
    sample_e = sel && sel_prev && (CPHA ? trail : lead);
    shift_e  = sel && sel_prev && (CPHA ? lead : trail);
  end

  // Next-state: select/deselect take priority over SCK edges in the same cycle
  always_comb begin
    sck_h_d       = sck_s;
    cs_h_d        = cs_s;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    first_d       = first_q;
    skip_d        = skip_q;
    load_d        = load_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_first_d    = 1'b0;
    tx_underrun_d = 1'b0;
    load_tx       = 1'b0;

    if (sel && !sel_prev) begin
      bit_cnt_d = '0;
      first_d   = 1'b1;
      skip_d    = CPHA;
      load_d    = 1'b0;
      load_tx   = 1'b1;
    end else if (!sel && sel_prev) begin
      bit_cnt_d  = '0;
      load_d     = 1'b0;
      rx_shift_d = '0;
    end else if (sample_e) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
        rx_valid_d = 1'b1;
        rx_first_d = first_q;
        first_d    = 1'b0;
        bit_cnt_d  = '0;
        load_d     = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (shift_e) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else if (load_q) begin
        load_d  = 1'b0;
        load_tx = 1'b1;
      end else begin
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
    end

    if (load_tx) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = FILL;
        tx_underrun_d = 1'b1;
      end
    end

    // A write in the same cycle as a load lands after the load has taken the old word
    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    tx_ready_d = ~hold_full_d;
    miso_oe_d  = sel;
    busy_d     = sel && (bit_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_h_q       <= 1'b0;
      cs_h_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      first_q       <= 1'b0;
      skip_q        <= 1'b0;
      load_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_ready_q    <= 1'b1;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sck_h_q       <= sck_h_d;
      cs_h_q        <= cs_h_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      first_q       <= first_d;
      skip_q        <= skip_d;
      load_q        <= load_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_first_q    <= rx_first_d;
      tx_underrun_q <= tx_underrun_d;
      tx_ready_q    <= tx_ready_d;
      miso_oe_q     <= miso_oe_d;
      busy_q        <= busy_d;
    end
  end

  assign miso        = tx_shift_q[WIDTH-1];
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_first    = rx_first_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;

endmodule
